hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//   Avalon-MM slave peripheral that owns the six-digit seven-segment display state.
//   - The Nios processor writes a 24-bit value plus per-digit blank and blink masks.
//   - The block drives 6 nibbles and a per-digit lit mask straight into the hex7seg decoders.
//   - It runs its own blink prescaler, so software never times the display.
// PARAMETERS
//   CLK_HZ    50_000_000  input clock frequency
//   BLINK_HZ  2           full blink period rate; phase half-period HALF = CLK_HZ/(2*BLINK_HZ) cycles
// PORTS
//   clk        in   1   system clock (CLOCK_50 domain)
//   reset      in   1   asynchronous, active-high reset
//   address    in   2   word address: 0 VALUE, 1 BLANK, 2 BLINK, 3 CTRL
//   write      in   1   write strobe, single cycle
//   writedata  in   32  write data
//   read       in   1   read strobe
//   readdata   out  32  read data, fixed read latency 1
//   hex_value  out  24  nibble i -> hex7seg digit i (bits 4i+3:4i)
//   digit_on   out  6   1 = digit i lit, 0 = digit forced blank
//   blink_tick out  1   one-cycle pulse at every blink phase toggle
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert by system): VALUE=0, BLANK=0, BLINK=0, CTRL=0x1
//     (bit0 DISP_EN=1), phase=1, prescaler=0, readdata=0, hex_value=0, digit_on=6'h3F, blink_tick=0.
//   - Writes: register updates on the clk edge where write=1; unused writedata bits ignored.
//     VALUE[23:0], BLANK[5:0], BLINK[5:0], CTRL[1:0].
//   - Reads: readdata is registered and valid the cycle after read=1; unused bits read 0.
//     CTRL reads {29'b0, phase, CTRL[1:0]} (bit2 = current blink phase, read-only).
//     readdata holds its last value when read=0.
//   - Read and write to the same address in one cycle: readdata returns the OLD value.
//   - Prescaler: counts 0..HALF-1 continuously. At HALF-1 it wraps to 0, phase toggles,
//     and blink_tick=1 for that cycle. HALF<1 is clamped to 1, giving a toggle every cycle.
//   - Outputs: registered, 1-cycle latency from any register or phase change.
//     hex_value <= VALUE.
//     digit_on <= DISP_EN ? (~BLANK & ~(BLINK & {6{~phase}})) : 6'h00.
//     BLANK dominates BLINK.
//   - Reset mid-operation: all state returns to the reset values immediately; no partial
//     write survives.
// CONFIGURATION
//   HEX_DISP_AUTOINC_EN
//   - Defined: CTRL bit1 AUTOINC is writable. When AUTOINC=1, VALUE increments by 1 on each
//     blink_tick cycle where phase goes 0->1. Wraps 24'hFFFFFF -> 24'h000000.
//     A processor write to VALUE in the same cycle wins over the increment.
//   - Undefined: CTRL bit1 reads 0, writes to it are ignored, VALUE changes only by writes.
// TESTING (sim with CLK_HZ=8, BLINK_HZ=1 -> HALF=4)
//   1. Reset mid-run with VALUE=0x123456 -> next cycle hex_value=0, digit_on=3F, CTRL reads 0x5.
//   2. Write VALUE=0xABCDEF, then read addr 0 -> readdata=0x00ABCDEF one cycle after read;
//      hex_value=ABCDEF one cycle after the write.
//   3. Write BLINK=0x03, BLANK=0x20 -> digit_on alternates 1F/1C, toggling every 4 cycles;
//      blink_tick pulses once per toggle.
//   4. Write CTRL=0 -> digit_on=00 next cycle regardless of the masks;
//      write CTRL=1 -> the masks are restored.
//   5. Write addr 1 with read addr 1 in the same cycle (old BLANK=0x0F, new 0x30)
//      -> readdata=0x0F, then a subsequent read returns 0x30.
//   6. [HEX_DISP_AUTOINC_EN] VALUE=0xFFFFFF, CTRL=0x3 -> next 0->1 phase gives VALUE=0x000000;
//      a VALUE write on that edge wins. [undefined] CTRL=0x3 reads back 0x1 | phase<<2.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave owning a six-digit seven-segment display: value, blank/blink masks, blink prescaler.
// Optional build macro HEX_DISP_AUTOINC_EN makes CTRL bit1 (AUTOINC) writable and enables VALUE auto-increment.
module hex_display_ctrl #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic [23:0] hex_value,
    output logic [5:0]  digit_on,
    output logic        blink_tick
);

    localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

`ifdef HEX_DISP_AUTOINC_EN
    localparam logic [1:0] CTRL_WMASK = 2'b11;
`else
    localparam logic [1:0] CTRL_WMASK = 2'b01;
`endif

    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_BLANK = 2'd1;
    localparam logic [1:0] ADDR_BLINK = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    logic [23:0]      value_q,      value_d;
    logic [5:0]       blank_q,      blank_d;
    logic [5:0]       blink_q,      blink_d;
    logic [1:0]       ctrl_q,       ctrl_d;
    logic             phase_q,      phase_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [31:0]      readdata_q,   readdata_d;
    logic [23:0]      hex_value_q,  hex_value_d;
    logic [5:0]       digit_on_q,   digit_on_d;
    logic             blink_tick_q, blink_tick_d;

    logic             wrap;
    logic [5:0]       lit;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:24];
    assign wrap         = (cnt_q == CNT_LAST);

    // A blinking digit is dark during phase 0; a blanked digit is dark always.
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        assign lit[gi] = ~blank_q[gi] & ~(blink_q[gi] & ~phase_q);
    end

    always_comb begin
        value_d      = value_q;
        blank_d      = blank_q;
        blink_d      = blink_q;
        ctrl_d       = ctrl_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q + CNT_W'(1);
        readdata_d   = readdata_q;
        blink_tick_d = 1'b0;

        if (wrap) begin
            cnt_d        = '0;
            phase_d      = ~phase_q;
            blink_tick_d = 1'b1;
        end

`ifdef HEX_DISP_AUTOINC_EN
        if (ctrl_q[1] && wrap && !phase_q) begin
            value_d = value_q + 24'd1;
        end
`endif

        // Processor writes are applied last so they win over the auto-increment.
        if (write) begin
            case (address)
                ADDR_VALUE: value_d = writedata[23:0];
                ADDR_BLANK: blank_d = writedata[5:0];
                ADDR_BLINK: blink_d = writedata[5:0];
                default:    ctrl_d  = writedata[1:0] & CTRL_WMASK;
            endcase
        end

        if (read) begin
            case (address)
                ADDR_VALUE: readdata_d = {8'h00, value_q};
                ADDR_BLANK: readdata_d = {26'd0, blank_q};
                ADDR_BLINK: readdata_d = {26'd0, blink_q};
                ADDR_CTRL:  readdata_d = {29'd0, phase_q, ctrl_q};
                default:    readdata_d = 32'd0;
            endcase
        end

        hex_value_d = value_q;
        digit_on_d  = ctrl_q[0] ? lit : 6'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q      <= 24'd0;
            blank_q      <= 6'd0;
            blink_q      <= 6'd0;
            ctrl_q       <= 2'b01;
            phase_q      <= 1'b1;
            cnt_q        <= '0;
            readdata_q   <= 32'd0;
            hex_value_q  <= 24'd0;
            digit_on_q   <= 6'h3F;
            blink_tick_q <= 1'b0;
        end else begin
            value_q      <= value_d;
            blank_q      <= blank_d;
            blink_q      <= blink_d;
            ctrl_q       <= ctrl_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            readdata_q   <= readdata_d;
            hex_value_q  <= hex_value_d;
            digit_on_q   <= digit_on_d;
            blink_tick_q <= blink_tick_d;
        end
    end

    assign readdata   = readdata_q;
    assign hex_value  = hex_value_q;
    assign digit_on   = digit_on_q;
    assign blink_tick = blink_tick_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with CLK_HZ=8, BLINK_HZ=1 (phase toggles every 4 cycles).
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic [23:0] hex_value;
    logic [5:0]  digit_on;
    logic        blink_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int k;  // clock edges since reset release

    hex_display_ctrl #(.CLK_HZ(8), .BLINK_HZ(1)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .hex_value(hex_value), .digit_on(digit_on), .blink_tick(blink_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    // Phase after kk edges: starts 1, toggles at every 4th edge.
    function automatic logic exp_phase(input int kk);
        return ((kk / 4) % 2) == 0;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        $display("[%0t] write addr=%0d data=%h", $time, a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] q);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        q = readdata;
        $display("[%0t] read  addr=%0d data=%h", $time, a, q);
    endtask

    task automatic test_reset();
        logic [31:0] q;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (hex_value !== 24'h0) begin n_fail++; $display("FAIL reset_hex: got %h want 000000", hex_value); end
        n_checks++; if (digit_on !== 6'h3F) begin n_fail++; $display("FAIL reset_digit: got %h want 3f", digit_on); end
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", readdata); end
        n_checks++; if (blink_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", blink_tick); end
        wr(2'd0, 32'h0012_3456);
        @(negedge clk);
        n_checks++; if (hex_value !== 24'h123456) begin n_fail++; $display("FAIL prereset_hex: got %h want 123456", hex_value); end
        // reset lands together with a VALUE write; the write must not survive
        address = 2'd0; writedata = 32'h0000_0777; write = 1'b1; reset = 1'b1;
        #1;
        n_checks++; if (hex_value !== 24'h0) begin n_fail++; $display("FAIL async_reset_hex: got %h want 000000", hex_value); end
        @(negedge clk);
        write = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_checks++; if (hex_value !== 24'h0) begin n_fail++; $display("FAIL midrun_hex: got %h want 000000", hex_value); end
        n_checks++; if (digit_on !== 6'h3F) begin n_fail++; $display("FAIL midrun_digit: got %h want 3f", digit_on); end
        rd(2'd3, q);
        n_checks++; if (q !== 32'h5) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00000005", q); end
        rd(2'd0, q);
        n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL reset_value: got %h want 00000000", q); end
    endtask

    task automatic test_value_write();
        logic [31:0] q;
        wr(2'd0, 32'hFFAB_CDEF);
        n_checks++; if (hex_value !== 24'h0) begin n_fail++; $display("FAIL value_latency: got %h want 000000", hex_value); end
        @(negedge clk);
        n_checks++; if (hex_value !== 24'hABCDEF) begin n_fail++; $display("FAIL value_hex: got %h want abcdef", hex_value); end
        rd(2'd0, q);
        n_checks++; if (q !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL value_read: got %h want 00abcdef", q); end
        address = 2'd1;
        repeat (3) @(negedge clk);
        n_checks++; if (readdata !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL rdata_hold: got %h want 00abcdef", readdata); end
    endtask

    task automatic test_blink();
        int ticks = 0;
        int toggles = 0;
        logic [5:0] prev;
        logic [5:0] want;
        wr(2'd2, 32'hFFFF_FF03);
        wr(2'd1, 32'h0000_0020);
        @(negedge clk);
        prev = digit_on;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            want = exp_phase(k - 1) ? 6'h1F : 6'h1C;
            n_checks++; if (digit_on !== want) begin n_fail++; $display("FAIL blink_digit k=%0d: got %h want %h", k, digit_on, want); end
            n_checks++; if (blink_tick !== ((k % 4) == 0)) begin n_fail++; $display("FAIL blink_tick k=%0d: got %b want %b", k, blink_tick, (k % 4) == 0); end
            if (blink_tick === 1'b1) ticks++;
            if (digit_on !== prev) toggles++;
            prev = digit_on;
        end
        n_checks++; if (ticks != 3) begin n_fail++; $display("FAIL blink_tick_count: got %0d want 3", ticks); end
        n_checks++; if (toggles != 3) begin n_fail++; $display("FAIL blink_toggle_count: got %0d want 3", toggles); end
    endtask

    task automatic test_disp_en();
        logic [5:0] want;
        wr(2'd3, 32'h0);
        @(negedge clk);
        n_checks++; if (digit_on !== 6'h00) begin n_fail++; $display("FAIL disp_off: got %h want 00", digit_on); end
        repeat (4) @(negedge clk);
        n_checks++; if (digit_on !== 6'h00) begin n_fail++; $display("FAIL disp_off_hold: got %h want 00", digit_on); end
        wr(2'd3, 32'h1);
        @(negedge clk);
        want = exp_phase(k - 1) ? 6'h1F : 6'h1C;
        n_checks++; if (digit_on !== want) begin n_fail++; $display("FAIL disp_on: got %h want %h", digit_on, want); end
    endtask

    task automatic test_rw_collision();
        logic [31:0] q;
        wr(2'd1, 32'h0000_000F);
        address = 2'd1; writedata = 32'h0000_0030; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        $display("[%0t] write+read addr=1 data=00000030 rdata=%h", $time, readdata);
        n_checks++; if (readdata !== 32'h0000_000F) begin n_fail++; $display("FAIL rw_old: got %h want 0000000f", readdata); end
        rd(2'd1, q);
        n_checks++; if (q !== 32'h0000_0030) begin n_fail++; $display("FAIL rw_new: got %h want 00000030", q); end
        rd(2'd2, q);
        n_checks++; if (q !== 32'h0000_0003) begin n_fail++; $display("FAIL blink_read: got %h want 00000003", q); end
    endtask

    task automatic test_ctrl();
        logic [31:0] q;
        logic [31:0] want;
        int kr;
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h0000_0010);
        wr(2'd3, 32'h3);
        kr = k;
        rd(2'd3, q);
`ifdef HEX_DISP_AUTOINC_EN
        want = 32'h3 | (exp_phase(kr) ? 32'h4 : 32'h0);
`else
        want = 32'h1 | (exp_phase(kr) ? 32'h4 : 32'h0);
`endif
        n_checks++; if (q !== want) begin n_fail++; $display("FAIL ctrl_read: got %h want %h", q, want); end
`ifndef HEX_DISP_AUTOINC_EN
        repeat (10) @(negedge clk);
        n_checks++; if (hex_value !== 24'h000010) begin n_fail++; $display("FAIL no_autoinc: got %h want 000010", hex_value); end
        n_checks++; if (digit_on !== 6'h3F) begin n_fail++; $display("FAIL ctrl_digit: got %h want 3f", digit_on); end
`endif
    endtask

`ifdef HEX_DISP_AUTOINC_EN
    task automatic test_autoinc();
        int budget;
        wr(2'd0, 32'h00FF_FFFF);
        wr(2'd3, 32'h3);
        budget = 0;
        do begin @(negedge clk); budget++; end while ((k % 8) != 0 && budget < 20);
        n_checks++; if ((k % 8) != 0) begin n_fail++; $display("FAIL autoinc_wait: got k=%0d want multiple of 8", k); end
        n_checks++; if (hex_value !== 24'hFFFFFF) begin n_fail++; $display("FAIL autoinc_pre: got %h want ffffff", hex_value); end
        @(negedge clk);
        n_checks++; if (hex_value !== 24'h000000) begin n_fail++; $display("FAIL autoinc_wrap: got %h want 000000", hex_value); end
        budget = 0;
        while ((k % 8) != 7 && budget < 20) begin @(negedge clk); budget++; end
        wr(2'd0, 32'h0000_0042);
        @(negedge clk);
        n_checks++; if (hex_value !== 24'h000042) begin n_fail++; $display("FAIL autoinc_write_wins: got %h want 000042", hex_value); end
        wr(2'd3, 32'h1);
    endtask
`endif

    initial begin
        test_reset();
        test_value_write();
        test_blink();
        test_disp_en();
        test_rw_collision();
        test_ctrl();
`ifdef HEX_DISP_AUTOINC_EN
        test_autoinc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
